// File: rtl/ram_scan_reader.sv
// ram_scan_reader: walks the read port of a small synchronous-read RAM one
// address at a time. It advances on an internal tick when run=1, or on a
// single-step pulse when run=0. The current address/data pair is presented
// to the display logic together with a capture strobe and a wrap strobe.
module ram_scan_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4,
  parameter int TICK_COUNT = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic [DATA_WIDTH-1:0] cur_data,
  output logic                  data_valid,
  output logic                  wrap
);

  // One spare bit keeps the terminal value representable for any TICK_COUNT.
  localparam int CNT_W = $clog2(TICK_COUNT) + 1;

  // ISSUE covers the RAM read latency, CAPTURE latches the new word and WAIT
  // holds the address while the display refreshes from the RAM.
  localparam logic [1:0] ST_ISSUE   = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(TICK_COUNT - 1);

  logic [1:0]            state_reg,      state_next;
  logic [CNT_W-1:0]      tick_cnt_reg,   tick_cnt_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg,    rd_addr_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg,   cur_addr_next;
  logic [DATA_WIDTH-1:0] cur_data_reg,   cur_data_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  wrap_reg,       wrap_next;
  logic                  advance;

  // Next-state logic: sequencing, tick counting and the advance decision.
  // rd_data only ever feeds the display registers, never the address.
  always_comb begin
    state_next      = state_reg;
    tick_cnt_next   = tick_cnt_reg;
    rd_addr_next    = rd_addr_reg;
    cur_addr_next   = cur_addr_reg;
    cur_data_next   = cur_data_reg;
    data_valid_next = 1'b0;
    wrap_next       = 1'b0;
    advance         = 1'b0;

    case (state_reg)
      ST_ISSUE: begin
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cur_addr_next   = rd_addr_reg;
        cur_data_next   = rd_data;
        data_valid_next = 1'b1;
        tick_cnt_next   = '0;
        state_next      = ST_WAIT;
      end
      ST_WAIT: begin
        // Live refresh so writes to the displayed word show up promptly.
        cur_data_next = rd_data;
        if (run) begin
          if (tick_cnt_reg == TICK_LAST) begin
            advance       = 1'b1;
            tick_cnt_next = '0;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end else begin
          tick_cnt_next = '0;
          advance       = step;
        end
      end
      default: begin
        state_next = ST_ISSUE;
      end
    endcase

    if (advance) begin
      rd_addr_next = rd_addr_reg + 1'b1;
      wrap_next    = (rd_addr_reg == ADDR_MAX);
      state_next   = ST_ISSUE;
    end
  end

  // State and output registers; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_ISSUE;
      tick_cnt_reg   <= '0;
      rd_addr_reg    <= '0;
      cur_addr_reg   <= '0;
      cur_data_reg   <= '0;
      data_valid_reg <= 1'b0;
      wrap_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick_cnt_next;
      rd_addr_reg    <= rd_addr_next;
      cur_addr_reg   <= cur_addr_next;
      cur_data_reg   <= cur_data_next;
      data_valid_reg <= data_valid_next;
      wrap_reg       <= wrap_next;
    end
  end

  assign rd_addr    = rd_addr_reg;
  assign cur_addr   = cur_addr_reg;
  assign cur_data   = cur_data_reg;
  assign data_valid = data_valid_reg;
  assign wrap       = wrap_reg;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: a 32x4 RAM with one-cycle read latency, random
// run/step/write stimulus, and a timing-rule reference model checked every
// cycle, plus a directed asynchronous reset in the middle of a read.
module tb_ram_scan_reader;

  localparam int AW   = 5;
  localparam int DW   = 4;
  localparam int TICK = 4;
  localparam int NW   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          step;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          data_valid;
  logic          wrap;

  logic [DW-1:0] mem [NW];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: addresses and counts as plain integers.
  int       m_addr;       // address currently driven to the RAM
  int       m_to_cap;     // edges until the next capture, 0 = waiting
  int       m_streak;     // consecutive waiting edges seen with run=1
  int       m_disp_addr;
  int       m_disp_data;
  int       m_rdq;        // what the RAM is currently presenting
  bit       m_dv;
  bit       m_wrap;

  ram_scan_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TICK_COUNT(TICK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cur_addr   (cur_addr),
    .cur_data   (cur_data),
    .data_valid (data_valid),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle synchronous read.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic preload();
    for (int a = 0; a < NW; a++) mem[a] = DW'(a[3:0] ^ 4'hA);
  endtask

  task automatic model_reset();
    m_addr      = 0;
    m_to_cap    = 2;
    m_streak    = 0;
    m_disp_addr = 0;
    m_disp_data = 0;
    m_dv        = 0;
    m_wrap      = 0;
  endtask

  // Apply the behaviour rules for one clock edge using the current inputs.
  task automatic model_edge();
    int old_addr = m_addr;
    int old_rdq  = m_rdq;
    bit adv      = 0;
    m_dv   = 0;
    m_wrap = 0;
    if (m_to_cap > 0) begin
      m_to_cap--;
      if (m_to_cap == 0) begin
        m_disp_addr = old_addr;
        m_disp_data = old_rdq;
        m_dv        = 1;
        m_streak    = 0;
      end
    end else begin
      m_disp_data = old_rdq;
      if (run) begin
        m_streak++;
        if (m_streak == TICK) begin
          adv      = 1;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
        adv      = step;
      end
    end
    if (adv) begin
      m_wrap   = (old_addr == NW - 1);
      m_addr   = (old_addr + 1) % NW;
      m_to_cap = 2;
    end
    m_rdq = int'(mem[old_addr]);
  endtask

  task automatic compare_all(input string where);
    check({where, ".rd_addr"},    32'(rd_addr),    32'(m_addr));
    check({where, ".cur_addr"},   32'(cur_addr),   32'(m_disp_addr));
    check({where, ".cur_data"},   32'(cur_data),   32'(m_disp_data));
    check({where, ".data_valid"}, 32'(data_valid), 32'(m_dv));
    check({where, ".wrap"},       32'(wrap),       32'(m_wrap));
  endtask

  // One clock: inputs are already set (at the negedge); update the model on
  // the edge, compare just after it, and return at the following negedge.
  task automatic tick(input string where);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(where);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    preload();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    m_rdq = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("in_reset");
    reset = 1'b0;

    // Idle after reset: one capture of address 0, then quiet.
    tick("idle");
    tick("idle");
    check("first_cur_data", 32'(cur_data), 32'h0000_000A);
    check("first_valid",    32'(data_valid), 32'd1);
    repeat (22) tick("idle");

    // Mixed random stimulus with occasional RAM writes.
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) run = ($urandom_range(0, 1) == 1);
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, NW - 1)] = DW'($urandom);
      tick("rand");
    end

    // Long auto-scan with step noise: guarantees at least one full wrap.
    run = 1'b1;
    for (int i = 0; i < 220; i++) begin
      step = ($urandom_range(0, 1) == 1);
      tick("scan");
    end

    // Walk to address 9 by single stepping, then reset while in ISSUE.
    preload();
    run   = 1'b0;
    step  = 1'b1;
    guard = 0;
    while (!(m_addr == 9 && m_to_cap == 2) && guard < 200) begin
      tick("walk");
      guard++;
    end
    check("reach_addr9_in_issue", 32'(m_addr == 9 && m_to_cap == 2), 32'd1);
    step = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async.rd_addr",    32'(rd_addr),    32'd0);
    check("async.cur_addr",   32'(cur_addr),   32'd0);
    check("async.cur_data",   32'(cur_data),   32'd0);
    check("async.data_valid", 32'(data_valid), 32'd0);
    check("async.wrap",       32'(wrap),       32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick("restart");
    tick("restart");
    check("restart_cur_addr", 32'(cur_addr),   32'd0);
    check("restart_cur_data", 32'(cur_data),   32'h0000_000A);
    check("restart_valid",    32'(data_valid), 32'd1);
    repeat (10) tick("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_scan_reader.md
Name: ram_scan_reader

Overview:
- Read-side counterpart to the switch-driven RAM write path.
- Walks a 32x4 synchronous-read RAM read port address by address. It advances on a programmable tick (auto-scan) or on a single-step pulse.
- Presents the current address/data pair to HEX decode logic, with a valid strobe and a wrap strobe.
- Sits between the RAM read port and the display logic in the top level. Inputs `run` and `step` arrive already synchronised through d_ff stages.

Parameters:
- ADDR_WIDTH, 5: RAM address width. Address space is 2^ADDR_WIDTH words.
- DATA_WIDTH, 4: RAM word width.
- TICK_COUNT, 50000000: WAIT-state cycles per auto-advance. Must be >= 1. Use 4 in simulation.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- reset  input  1  asynchronous, active-high reset
- run  input  1  1 = auto-scan using the tick counter; 0 = manual stepping
- step  input  1  one-cycle advance request; honoured only when run=0
- rd_addr  output  ADDR_WIDTH  RAM read address; registered
- rd_data  input  DATA_WIDTH  RAM read data = mem[rd_addr sampled at the previous clk edge]
- cur_addr  output  ADDR_WIDTH  address of the word currently displayed
- cur_data  output  DATA_WIDTH  data of the word currently displayed
- data_valid  output  1  one-cycle pulse when a newly addressed word is captured
- wrap  output  1  one-cycle pulse when rd_addr rolls from max to 0

Behaviour:
- Reset state, applied immediately without waiting for a clk edge:
  - rd_addr=0, cur_addr=0, cur_data=0, data_valid=0, wrap=0
  - tick counter=0, state=ISSUE
- After reset release, address 0 is read automatically.
- ISSUE:
  - rd_addr is held.
  - One cycle for RAM read latency.
  - Next state is CAPTURE.
- CAPTURE:
  - cur_data <= rd_data; cur_addr <= rd_addr; data_valid <= 1 for exactly one cycle.
  - Tick counter cleared.
  - Next state is WAIT.
- WAIT:
  - rd_addr is stable. cur_data <= rd_data every cycle, so RAM writes to the displayed address appear within 2 cycles. data_valid stays 0.
  - run=1: counter increments each cycle. On the cycle with counter == TICK_COUNT-1, perform an advance.
  - run=0: counter is held at 0. step=1 performs an advance.
- Advance:
  - rd_addr <= rd_addr+1, modulo 2^ADDR_WIDTH.
  - wrap <= 1 for one cycle iff the old rd_addr == 2^ADDR_WIDTH-1.
  - Next state is ISSUE.
- Latency:
  - The data_valid pulse occurs 2 clk edges after the advance edge.
  - Auto-scan pulse spacing is TICK_COUNT+2 cycles.
- step is ignored in ISSUE and CAPTURE, and whenever run=1. It is never queued.
- run falling mid-count: counter clears to 0 and no advance occurs. run rising: counting restarts from 0.
- cur_addr and cur_data always update together in CAPTURE. They never show a mixed old/new pair.
- Reset mid-operation, in any state: outputs return to reset values immediately. The scan restarts at address 0 after release.
- wrap and data_valid are registered outputs. They are never both high in the same cycle.
- Implementation: 3-state FSM, registered tick counter of width clog2(TICK_COUNT)+1, no combinational path from rd_data to rd_addr.

Test Plan:
- Bench setup: RAM model with 1-cycle synchronous read, preloaded mem[a] = a[3:0] ^ 4'hA; TICK_COUNT=4.
- Reset, run=0, step=0 -> cur_addr=0 and cur_data=4'hA at the 2nd edge after release. Exactly one data_valid pulse, then none for 20 cycles. rd_addr stays 0.
- Manual step, run=0: step pulse in WAIT -> rd_addr=1 at the next edge. data_valid 2 edges later with cur_addr=1, cur_data=4'hB. A step asserted during ISSUE/CAPTURE has no effect.
- Auto-scan, run=1 from addr 0 -> data_valid pulses every 6 cycles. cur_addr sequence is 1,2,3,... and cur_data is 4'hB,4'h8,4'h9,... Asserting step simultaneously causes no extra advance.
- Wrap: with rd_addr=31 and run=1 -> rd_addr=0 and a one-cycle wrap pulse on the advance. Following capture gives cur_addr=0, cur_data=4'hA. No wrap at 30->31.
- Live refresh: in WAIT at addr 5, bench changes mem[5] from 4'hF to 4'h3 -> cur_data=4'h3 within 2 cycles, cur_addr unchanged, no data_valid.
- Reset asserted asynchronously between clk edges while in ISSUE at addr 9 -> all outputs 0 before the next edge. After release, capture of addr 0 with cur_data=4'hA.
